// File: rtl/cfg_scan_chain_if.sv
// Port bundle for cfg_scan_chain: serial scan stream, frame control pulses and status.
// Handshake: COMMIT is the only transfer. It completes a frame only when READY is high
// and SCAN_EN is low. A COMMIT at any other time is dropped and ERR is raised.
interface cfg_scan_chain_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             SCAN_EN;
    logic             SCAN_IN;
    logic             SCAN_OUT;
    logic             COMMIT;
    logic             CAPTURE;
    logic             ERR_CLR;
    logic [WIDTH-1:0] CFG_OUT;
    logic             READY;
    logic             ERR;
    logic [CNT_W-1:0] BIT_CNT;
    logic [1:0]       DBG_STATE;

    modport master (
        output SCAN_EN, SCAN_IN, COMMIT, CAPTURE, ERR_CLR,
        input  SCAN_OUT, CFG_OUT, READY, ERR, BIT_CNT, DBG_STATE
    );

    modport slave (
        input  SCAN_EN, SCAN_IN, COMMIT, CAPTURE, ERR_CLR,
        output SCAN_OUT, CFG_OUT, READY, ERR, BIT_CNT, DBG_STATE
    );
endinterface

// File: rtl/cfg_scan_chain.sv
// Configuration scan chain: serial shift register, atomic commit to a shadow register,
// readback capture and a sticky protocol-error flag. Every output comes from a flop.
module cfg_scan_chain #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] DEFAULT_CFG = '0
) (
    input logic             CLK,
    input logic             RESET,
    cfg_scan_chain_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SHIFTING = 2'b01;
    localparam logic [1:0] ST_FULL     = 2'b10;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             err_set;

    always_comb begin
        shift_d = shift_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        err_set = 1'b0;

        if (bus.SCAN_EN) begin
            // Shifting always wins. Shifts made while FULL pass the data on to the next tile.
            shift_d = {bus.SCAN_IN, shift_q[WIDTH-1:1]};
            if (cnt_q != FULL_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = (cnt_d == FULL_CNT) ? ST_FULL : ST_SHIFTING;
            err_set = bus.COMMIT | bus.CAPTURE;
        end else if (bus.COMMIT) begin
            if (state_q == ST_FULL) begin
                cfg_d   = shift_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                err_set = 1'b1;
            end
            if (bus.CAPTURE) begin
                err_set = 1'b1;
            end
        end else if (bus.CAPTURE) begin
            shift_d = cfg_q;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end

        // A new error in the same cycle as ERR_CLR leaves the flag set.
        err_d   = err_set | (err_q & ~bus.ERR_CLR);
        ready_d = (state_d == ST_FULL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift_q <= '0;
            cfg_q   <= DEFAULT_CFG;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.SCAN_OUT  = shift_q[0];
    assign bus.CFG_OUT   = cfg_q;
    assign bus.READY     = ready_q;
    assign bus.ERR       = err_q;
    assign bus.BIT_CNT   = cnt_q;
    assign bus.DBG_STATE = state_q;
endmodule

// File: tb/tb_cfg_scan_chain.sv
// Directed bench for cfg_scan_chain with WIDTH=16 and DEFAULT_CFG=16'h00FF.
module tb_cfg_scan_chain;
    localparam int               W   = 16;
    localparam logic [W-1:0]     DEF = 16'h00FF;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    cfg_scan_chain_if #(.WIDTH(W)) bus ();

    cfg_scan_chain #(.WIDTH(W), .DEFAULT_CFG(DEF)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // driver: apply one cycle of inputs at the falling edge, return 1 time unit after the rising edge
    task automatic cycle(input logic rst, input logic en, input logic din,
                         input logic commit, input logic capture, input logic clr);
        @(negedge CLK);
        RESET       = rst;
        bus.SCAN_EN = en;
        bus.SCAN_IN = din;
        bus.COMMIT  = commit;
        bus.CAPTURE = capture;
        bus.ERR_CLR = clr;
        @(posedge CLK);
        #1;
        RESET       = 1'b0;
        bus.SCAN_EN = 1'b0;
        bus.SCAN_IN = 1'b0;
        bus.COMMIT  = 1'b0;
        bus.CAPTURE = 1'b0;
        bus.ERR_CLR = 1'b0;
    endtask

    task automatic shift_bits(input logic [W-1:0] data, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, data[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'h00FF) begin errors++; $display("FAIL reset_cfg got %h want 00ff", bus.CFG_OUT); end
        checks++; if (bus.SCAN_OUT !== 1'b0) begin errors++; $display("FAIL reset_scan_out got %b want 0", bus.SCAN_OUT); end
        checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.READY); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.ERR); end
        checks++; if (bus.BIT_CNT !== 5'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", bus.BIT_CNT); end
        checks++; if (bus.DBG_STATE !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", bus.DBG_STATE); end
    endtask

    task automatic test_full_frame;
        logic [W-1:0] frame;
        frame = 16'hA5C3;
        for (int i = 0; i < W; i++) begin
            cycle(1'b0, 1'b1, frame[i], 1'b0, 1'b0, 1'b0);
            checks++; if (bus.CFG_OUT !== 16'h00FF) begin errors++; $display("FAIL frame_cfg_stable bit %0d got %h want 00ff", i, bus.CFG_OUT); end
            if (i == 0) begin
                checks++; if (bus.DBG_STATE !== 2'b01) begin errors++; $display("FAIL frame_state_shifting got %b want 01", bus.DBG_STATE); end
            end
            if (i == W - 2) begin
                checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL frame_ready_early got %b want 0", bus.READY); end
            end
        end
        checks++; if (bus.BIT_CNT !== 5'd16) begin errors++; $display("FAIL frame_bit_cnt got %0d want 16", bus.BIT_CNT); end
        checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL frame_ready got %b want 1", bus.READY); end
        checks++; if (bus.DBG_STATE !== 2'b10) begin errors++; $display("FAIL frame_state_full got %b want 10", bus.DBG_STATE); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'hA5C3) begin errors++; $display("FAIL commit_cfg got %h want a5c3", bus.CFG_OUT); end
        checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL commit_ready got %b want 0", bus.READY); end
        checks++; if (bus.BIT_CNT !== 5'd0) begin errors++; $display("FAIL commit_bit_cnt got %0d want 0", bus.BIT_CNT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL commit_err got %b want 0", bus.ERR); end
    endtask

    task automatic test_short_frame;
        shift_bits(16'h03FF, 10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'hA5C3) begin errors++; $display("FAIL short_cfg got %h want a5c3", bus.CFG_OUT); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", bus.ERR); end
        checks++; if (bus.BIT_CNT !== 5'd10) begin errors++; $display("FAIL short_bit_cnt got %0d want 10", bus.BIT_CNT); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.ERR); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", bus.ERR); end
        // rejected commit together with ERR_CLR: the new error must stay
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", bus.ERR); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b want 0", bus.ERR); end
    endtask

    task automatic test_readback;
        int exp_seq[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.BIT_CNT !== 5'd0) begin errors++; $display("FAIL capture_bit_cnt got %0d want 0", bus.BIT_CNT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL capture_err got %b want 0", bus.ERR); end
        for (int k = 0; k < W; k++) begin
            if (k > 0) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.SCAN_OUT !== exp_seq[k][0]) begin
                errors++; $display("FAIL readback bit %0d got %b want %0d", k, bus.SCAN_OUT, exp_seq[k]);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL readback_ready got %b want 1", bus.READY); end
        checks++; if (bus.CFG_OUT !== 16'hA5C3) begin errors++; $display("FAIL readback_cfg got %h want a5c3", bus.CFG_OUT); end
    endtask

    task automatic test_collisions;
        // FULL with an all-zero chain; commit with a shift: shift taken, commit dropped
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'hA5C3) begin errors++; $display("FAIL coll_shift_cfg got %h want a5c3", bus.CFG_OUT); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL coll_shift_err got %b want 1", bus.ERR); end
        checks++; if (bus.BIT_CNT !== 5'd16) begin errors++; $display("FAIL coll_shift_cnt got %0d want 16", bus.BIT_CNT); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // chain now holds 16'h8000; commit with capture: commit taken, error raised
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'h8000) begin errors++; $display("FAIL coll_cap_cfg got %h want 8000", bus.CFG_OUT); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL coll_cap_err got %b want 1", bus.ERR); end
        checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL coll_cap_ready got %b want 0", bus.READY); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // capture with a shift: shift taken (chain 16'h4000), error raised
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.BIT_CNT !== 5'd1) begin errors++; $display("FAIL coll_capsh_cnt got %0d want 1", bus.BIT_CNT); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL coll_capsh_err got %b want 1", bus.ERR); end
        checks++; if (bus.SCAN_OUT !== 1'b0) begin errors++; $display("FAIL coll_capsh_out got %b want 0", bus.SCAN_OUT); end
    endtask

    task automatic test_reset_mid;
        shift_bits(16'hFFFF, 6);
        checks++; if (bus.BIT_CNT !== 5'd7) begin errors++; $display("FAIL mid_pre_cnt got %0d want 7", bus.BIT_CNT); end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.BIT_CNT !== 5'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", bus.BIT_CNT); end
        checks++; if (bus.CFG_OUT !== 16'h00FF) begin errors++; $display("FAIL mid_cfg got %h want 00ff", bus.CFG_OUT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", bus.ERR); end
        checks++; if (bus.SCAN_OUT !== 1'b0) begin errors++; $display("FAIL mid_scan_out got %b want 0", bus.SCAN_OUT); end
        shift_bits(16'h5A0F, W);
        checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", bus.READY); end
        checks++; if (bus.SCAN_OUT !== 1'b1) begin errors++; $display("FAIL mid_scan_out_lsb got %b want 1", bus.SCAN_OUT); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'h5A0F) begin errors++; $display("FAIL mid_commit_cfg got %h want 5a0f", bus.CFG_OUT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL mid_commit_err got %b want 0", bus.ERR); end
        // reset beats a legal commit
        shift_bits(16'hFFFF, W);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.CFG_OUT !== 16'h00FF) begin errors++; $display("FAIL rst_over_commit got %h want 00ff", bus.CFG_OUT); end
        checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL rst_over_ready got %b want 0", bus.READY); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RESET       = 1'b1;
        bus.SCAN_EN = 1'b0;
        bus.SCAN_IN = 1'b0;
        bus.COMMIT  = 1'b0;
        bus.CAPTURE = 1'b0;
        bus.ERR_CLR = 1'b0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_readback();
        test_collisions();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_scan_chain.md
# cfg_scan_chain

Parametrised configuration scan chain: a WIDTH-bit serial shift register with a shadow (hold) register, frame-length checking and readback capture. It is the configuration-memory primitive for fabric tiles. Bits stream in on SCAN_IN while SCAN_EN is high, are committed atomically to CFG_OUT on COMMIT, and SCAN_OUT allows chains to be daisy-chained tile to tile. CFG_OUT never glitches while a new frame is being shifted.

## Interface
- WIDTH, 16: chain length and CFG_OUT width; legal range is 2 to 1024.
- DEFAULT_CFG, {WIDTH{1'b0}}: value loaded into CFG_OUT on reset.
- CNT_W, $clog2(WIDTH+1): width of BIT_CNT. Derived; not overridden.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  reset; synchronous, active-high.
- SCAN_EN  input  1  shift enable; one bit is shifted per cycle while high.
- SCAN_IN  input  1  serial data in, sent LSB first.
- SCAN_OUT  output  1  serial data out; equals shift_reg[0], driven straight from a flop.
- COMMIT  input  1  single-cycle pulse that copies the shift register to CFG_OUT.
- CAPTURE  input  1  single-cycle pulse that copies CFG_OUT into the shift register for readback.
- ERR_CLR  input  1  clears ERR.
- CFG_OUT  output  WIDTH  active configuration (shadow register).
- READY  output  1  high when exactly a full frame (WIDTH bits) has been shifted since the last COMMIT, CAPTURE or RESET.
- ERR  output  1  sticky protocol-error flag.
- BIT_CNT  output  CNT_W  number of bits shifted in the current frame; saturates at WIDTH.

## Operation
- State machine:
  - IDLE (BIT_CNT=0)
  - SHIFTING (0<BIT_CNT<WIDTH)
  - FULL (BIT_CNT=WIDTH; READY=1)
- Shift, when SCAN_EN=1: shift_reg <= {SCAN_IN, shift_reg[WIDTH-1:1]}; BIT_CNT <= min(BIT_CNT+1, WIDTH).
  - IDLE→SHIFTING on the first shift. SHIFTING→FULL when BIT_CNT reaches WIDTH.
  - Further shifts while FULL keep shifting (pass-through for daisy chains). The state stays FULL.
- COMMIT with SCAN_EN=0:
  - In FULL: CFG_OUT <= shift_reg; BIT_CNT <= 0; go to IDLE.
  - In IDLE or SHIFTING: rejected. CFG_OUT and BIT_CNT are unchanged and ERR <= 1.
- CAPTURE with SCAN_EN=0 and COMMIT=0: shift_reg <= CFG_OUT; BIT_CNT <= 0; go to IDLE. This is legal in any state and sets no error. Shifting out WIDTH bits afterwards reads back CFG_OUT LSB first.
- Simultaneous events:
  - SCAN_EN with COMMIT and/or CAPTURE: the shift is performed, COMMIT/CAPTURE is ignored and ERR <= 1.
  - COMMIT with CAPTURE (SCAN_EN=0): COMMIT wins (normal COMMIT rules apply) and ERR <= 1.
- ERR is sticky:
  - Cleared only by RESET or ERR_CLR.
  - If ERR_CLR is high in the same cycle as a new error, the set wins.
- RESET, any state including mid-shift: shift_reg <= 0, CFG_OUT <= DEFAULT_CFG, BIT_CNT <= 0, ERR <= 0, go to IDLE. RESET overrides every other input.

## Timing
- Reset values: SCAN_OUT=0, CFG_OUT=DEFAULT_CFG, READY=0, ERR=0, BIT_CNT=0. They are visible after the first rising edge with RESET=1.
- SCAN_OUT: the bit presented on SCAN_IN emerges WIDTH cycles of SCAN_EN later. SCAN_OUT changes only on shift edges and on CAPTURE.
- READY is registered. It rises in the cycle after the WIDTH-th shift edge and falls in the cycle after the COMMIT or CAPTURE edge.
- CFG_OUT updates on the COMMIT edge, i.e. it is visible one cycle after COMMIT is sampled. It is otherwise stable, with no intermediate values during shifting.
- ERR is visible one cycle after the offending edge.
- There is no combinational path from any input to any output.

## Test plan
- Reset values: assert RESET for 2 cycles with DEFAULT_CFG=16'h00FF → CFG_OUT=16'h00FF, SCAN_OUT=0, READY=0, ERR=0, BIT_CNT=0.
- Full frame and commit: shift 16'hA5C3 LSB first (16 cycles) → BIT_CNT=16 and READY=1; pulse COMMIT → CFG_OUT=16'hA5C3 next cycle, READY=0, BIT_CNT=0, ERR=0.
- Short frame: shift 10 bits, then pulse COMMIT → CFG_OUT unchanged, ERR=1, BIT_CNT=10; pulse ERR_CLR → ERR=0.
- Readback: with CFG_OUT=16'hA5C3, pulse CAPTURE, then shift 16 cycles with SCAN_IN=0 → SCAN_OUT sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first).
- Collisions: COMMIT together with SCAN_EN while FULL → shift occurs, CFG_OUT unchanged, ERR=1. COMMIT together with CAPTURE while FULL → commit taken, ERR=1.
- Reset mid-operation: assert RESET after 7 shifts → BIT_CNT=0, CFG_OUT=DEFAULT_CFG; a following 16-bit frame and COMMIT load correctly.
